res_buffer_acc: RTL and testbench
=================================

Name: res_buffer_acc

Overview:
- Multi-lane result buffer that sits between the PE array output and the writeback/DMA stage of the NPU.
- Each cycle it stores one row of LANES results at a row address. A row is either overwritten or saturating-accumulated into the existing contents, which supports partial-sum tiling.
- On command it drains all DEPTH rows, in address order, over a valid/ready stream.

Parameters:
- BIT_DEPTH, 8, width of one signed lane element
- LANES, 4, elements per row
- DEPTH, 26, number of rows
- ADDR_WIDTH, 5, row address width; must satisfy 2^ADDR_WIDTH >= DEPTH

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  row write request
- wr_acc  in  1  1 = accumulate into the row, 0 = overwrite the row
- wr_addr  in  ADDR_WIDTH  row address
- wr_data  in  LANES*BIT_DEPTH  row data; lane i occupies [i*BIT_DEPTH +: BIT_DEPTH]
- drain_start  in  1  start a full drain
- out_valid  out  1  out_data holds a valid row
- out_ready  in  1  consumer accepts the row
- out_data  out  LANES*BIT_DEPTH  drained row
- out_addr  out  ADDR_WIDTH  row index of out_data
- out_last  out  1  out_data is row DEPTH-1
- busy  out  1  drain in progress
- err_oob  out  1  one-cycle pulse when a write is dropped

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - out_valid, out_last, busy, err_oob = 0
  - out_data, out_addr = 0
  - FSM = IDLE, rd_ptr = 0
  - Row storage is not reset; its contents are undefined until written.
- FSM states: IDLE and DRAIN.
  - IDLE -> DRAIN when drain_start=1.
  - DRAIN -> IDLE on the clock edge where out_valid & out_ready & out_last.
  - busy = 1 exactly while in DRAIN.
- Writes:
  - Accepted only in IDLE, and only when wr_addr < DEPTH.
  - The write takes effect at the clock edge.
  - wr_acc=0: the row is replaced with wr_data.
  - wr_acc=1: each lane becomes sat(stored + wr_data), a signed BIT_DEPTH add clamped to [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1].
  - Read-modify-write uses the stored value as of the current cycle, so back-to-back accumulates to the same row each see the previous result (no hazard).
- Dropped writes:
  - A write with wr_addr >= DEPTH, or any write while in DRAIN, is dropped and leaves storage unchanged.
  - err_oob = 1 in the cycle after the dropped write.
- Drain:
  - Entering DRAIN sets rd_ptr = 0.
  - In DRAIN, the output register loads row[rd_ptr] (plus out_addr = rd_ptr, out_last = (rd_ptr == DEPTH-1)) and rd_ptr increments whenever (!out_valid | out_ready) and rows remain.
  - out_valid first rises one cycle after drain_start.
  - With out_ready held high, throughput is one row per cycle, so the drain completes DEPTH cycles after drain_start.
  - out_data, out_addr and out_last stay stable while out_valid & !out_ready.
  - out_valid falls after the final handshake.
- Simultaneous and corner events:
  - wr_en with drain_start in IDLE: the write is performed, and row 0 is loaded the following cycle, so the write is visible in the drain.
  - drain_start while in DRAIN is ignored.
  - A reset mid-drain returns to IDLE with out_valid = 0; stored rows are retained.
  - DEPTH=1 gives a single-beat drain with out_last = 1.

Optional Feature:
- Macro: RES_BUF_CLEAR_ON_DRAIN_EN.
- With the macro defined, each row is written to zero on the cycle it is loaded into the output register. After a complete drain every row reads 0, so accumulation can restart without an overwrite pass.
- Without the macro, drain is non-destructive and rows keep their values.

Decomposition:
- Shared package npu_pkg:
  - FSM state typedef (IDLE, DRAIN)
  - saturating-add function sat_add(a, b, BIT_DEPTH)
- One natural sub-module: res_lane_sat_add, a combinational per-lane signed saturating adder instantiated LANES times by generate.
- Storage stays inline as a single row-wide array.

Test Plan:
- Overwrite then drain, out_ready=1:
  - Stimulus: write row r = {r+3, r+2, r+1, r} for r = 0..25, then pulse drain_start.
  - Response: 26 consecutive beats carrying the same values; out_addr 0..25; out_last only on beat 25; busy falls after beat 25.
- Saturation:
  - Stimulus: overwrite row 2 with lanes {100, -100, 5, 0}, then accumulate {100, -100, -10, 0}.
  - Response: drain shows {127, -128, -5, 0}.
- Backpressure:
  - Stimulus: out_ready random at 50%.
  - Response: every beat is held stable until accepted; no row is skipped or duplicated; the count is 26.
- Errors:
  - Stimulus: write to wr_addr 26, and a write to row 0 during DRAIN.
  - Response: err_oob pulses each time; row 0 keeps its prior value.
- Reset during DRAIN:
  - Stimulus: assert rst_n=0 at beat 10, then drain again.
  - Response: out_valid=0 and busy=0 after reset; the second drain returns the original rows 0..25.
- Macro RES_BUF_CLEAR_ON_DRAIN_EN:
  - Stimulus: perform two consecutive drains.
  - Response: the second drain returns all zeros; without the macro it repeats the data.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions for the result buffer.
//   state_t  : drain controller state (IDLE, DRAIN)
//   sat_add  : signed add of two values, clamped to a signed field of
//              'width' bits (width <= 63)
package npu_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic longint sat_add(input longint a,
                                     input longint b,
                                     input int unsigned width);
    longint sum;
    longint hi;
    longint lo;
    sum = a + b;
    hi  = (longint'(1) <<< (width - 1)) - longint'(1);
    lo  = -(longint'(1) <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/res_lane_sat_add.sv
// Combinational signed saturating adder for one result lane.
// Ports:
//   a, b : signed BIT_DEPTH-bit operands (stored value, incoming value)
//   y    : a + b clamped to [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1]
module res_lane_sat_add
  import npu_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 8
) (
  input  logic signed [BIT_DEPTH-1:0] a,
  input  logic signed [BIT_DEPTH-1:0] b,
  output logic signed [BIT_DEPTH-1:0] y
);

  always_comb begin
    y = BIT_DEPTH'(sat_add(longint'(a), longint'(b), BIT_DEPTH));
  end

endmodule

// File: rtl/res_buffer_acc.sv
// Multi-lane result buffer between the PE array and writeback/DMA.
// Stores one LANES-wide row per cycle (overwrite or saturating accumulate)
// and, on drain_start, streams all DEPTH rows in address order over a
// valid/ready interface.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_en/wr_acc      : row write request; 1 = accumulate, 0 = overwrite
//   wr_addr/wr_data   : row address and row data (lane i at [i*BIT_DEPTH +: BIT_DEPTH])
//   drain_start       : begin a full drain (ignored while draining)
//   out_valid/ready   : drain stream handshake
//   out_data/addr/last: drained row, its index, and last-row flag
//   busy              : drain in progress
//   err_oob           : one-cycle pulse after a dropped write
// Build option:
//   RES_BUF_CLEAR_ON_DRAIN_EN : when defined, each row is zeroed as it is
//   loaded into the output register (destructive drain).
module res_buffer_acc
  import npu_pkg::*;
#(
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned DEPTH      = 26,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         wr_acc,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [LANES*BIT_DEPTH-1:0]   wr_data,
  input  logic                         drain_start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*BIT_DEPTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err_oob
);

  localparam int unsigned ROW_W = LANES * BIT_DEPTH;
  // Compare addresses one bit wider so DEPTH == 2^ADDR_WIDTH still works.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

  logic [ROW_W-1:0] mem [DEPTH];

  state_t               state;
  logic [ADDR_WIDTH:0]  rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                 addr_ok;
  logic                 wr_ok;
  logic                 load;
  logic [ROW_W-1:0]     stored_row;
  logic [ROW_W-1:0]     acc_row;
  logic [ROW_W-1:0]     next_row;

  assign busy    = (state == DRAIN);
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign addr_ok = ({1'b0, wr_addr} < DEPTH_W);
  assign wr_ok   = wr_en && (state == IDLE) && addr_ok;

  // Read-modify-write sees the current stored row, so back-to-back
  // accumulates to the same row chain correctly.
  assign stored_row = mem[wr_addr];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    res_lane_sat_add #(
      .BIT_DEPTH(BIT_DEPTH)
    ) u_sat (
      .a(stored_row[i*BIT_DEPTH +: BIT_DEPTH]),
      .b(wr_data[i*BIT_DEPTH +: BIT_DEPTH]),
      .y(acc_row[i*BIT_DEPTH +: BIT_DEPTH])
    );
  end

  assign next_row = wr_acc ? acc_row : wr_data;

  // Output register refills whenever it is empty or being consumed.
  assign load = (state == DRAIN) && (rd_ptr < DEPTH_W) && (!out_valid || out_ready);

  // Storage has no reset; writes and drain-clears never overlap because
  // writes are only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_ok) begin
        mem[wr_addr] <= next_row;
      end
`ifdef RES_BUF_CLEAR_ON_DRAIN_EN
      else if (load) begin
        mem[rd_addr] <= '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      err_oob <= wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (drain_start) begin
            state  <= DRAIN;
            rd_ptr <= '0;
          end
        end
        DRAIN: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_addr];
            out_addr  <= rd_addr;
            out_last  <= (rd_ptr == LAST_W);
            rd_ptr    <= rd_ptr + ONE_W;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_buffer_acc.sv
module tb_res_buffer_acc;

  localparam int DP = 26;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic          wr_acc;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          drain_start;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          err_oob;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rows [DP];

  typedef struct {
    logic          acc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          exp_err;
  } wvec_t;

  wvec_t vt [8];

  always #5 clk = ~clk;

  res_buffer_acc #(
    .BIT_DEPTH(8),
    .LANES(4),
    .DEPTH(DP),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_acc(wr_acc),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .drain_start(drain_start),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .out_last(out_last),
    .busy(busy),
    .err_oob(err_oob)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic write_row(input int addr, input logic [31:0] data, input logic acc,
                           input logic exp_err);
    wr_en   = 1'b1;
    wr_acc  = acc;
    wr_addr = AW'(addr);
    wr_data = data;
    tick;
    wr_en = 1'b0;
    chk("err_oob_after_write", 32'(err_oob), 32'(exp_err));
  endtask

  task automatic load_base_rows;
    for (int r = 0; r < DP; r++) begin
      exp_rows[r] = pack4(r, r + 1, r + 2, r + 3);
      write_row(r, exp_rows[r], 1'b0, 1'b0);
    end
  endtask

  task automatic clear_expect(input int upto);
`ifdef RES_BUF_CLEAR_ON_DRAIN_EN
    for (int r = 0; r <= upto; r++) exp_rows[r] = '0;
`else
    if (upto < 0) exp_rows[0] = exp_rows[0];
`endif
  endtask

  // mode 1: write row 0 while draining (must be dropped)
  // mode 2: write row 5 in the same cycle as drain_start (must be visible)
  task automatic run_drain(input int ready_pct, input int mode, input int abort_at);
    int beats = 0;
    int cycles = 0;
    int gaps = 0;
    bit held = 1'b0;
    bit seen = 1'b0;
    logic [31:0]   hd;
    logic [AW-1:0] ha;
    logic          hl;

    out_ready   = 1'b0;
    drain_start = 1'b1;
    if (mode == 2) begin
      exp_rows[5] = pack4(-7, 55, -99, 1);
      wr_en   = 1'b1;
      wr_acc  = 1'b0;
      wr_addr = AW'(5);
      wr_data = exp_rows[5];
    end
    tick;
    drain_start = 1'b0;
    wr_en       = 1'b0;
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("valid_not_yet", 32'(out_valid), 32'd0);
    if (mode == 2) chk("err_simul_write", 32'(err_oob), 32'd0);

    if (mode == 1) begin
      wr_en   = 1'b1;
      wr_acc  = 1'b0;
      wr_addr = '0;
      wr_data = 32'hA5A5_A5A5;
      drain_start = 1'b1;
      tick;
      wr_en = 1'b0;
      drain_start = 1'b0;
      cycles++;
      chk("err_write_in_drain", 32'(err_oob), 32'd1);
    end

    while (beats < DP && cycles < 400) begin
      if (abort_at >= 0 && beats == abort_at) break;
      if (held) begin
        chk("hold_data", out_data, hd);
        chk("hold_addr", 32'(out_addr), 32'(ha));
        chk("hold_last", 32'(out_last), 32'(hl));
      end
      if (out_valid) begin
        seen = 1'b1;
        out_ready = (ready_pct >= 100) || ($urandom_range(0, 99) < ready_pct);
        if (out_ready) begin
          chk("beat_data", out_data, exp_rows[beats]);
          chk("beat_addr", 32'(out_addr), 32'(beats));
          chk("beat_last", 32'(out_last), 32'(beats == DP - 1));
          beats++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = out_data;
          ha = out_addr;
          hl = out_last;
        end
      end else begin
        if (seen) gaps++;
        out_ready = ($urandom_range(0, 1) == 1);
      end
      tick;
      cycles++;
    end

    if (abort_at >= 0) begin
      chk("abort_reached", 32'(beats), 32'(abort_at));
      rst_n = 1'b0;
      out_ready = 1'b0;
      tick;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_last", 32'(out_last), 32'd0);
      rst_n = 1'b1;
      tick;
      return;
    end

    out_ready = 1'b0;
    chk("drain_beat_count", 32'(beats), 32'(DP));
    chk("valid_after_drain", 32'(out_valid), 32'd0);
    chk("busy_after_drain", 32'(busy), 32'd0);
    chk("stream_gaps", 32'(gaps), 32'd0);
    tick;
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_en       = 1'b0;
    wr_acc      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    drain_start = 1'b0;
    out_ready   = 1'b0;
    tick;
    tick;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_oob), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    rst_n = 1'b1;
    tick;

    load_base_rows();

    vt[0] = '{1'b0, AW'(2),  pack4(100, -100, 5, 0),     1'b0};
    vt[1] = '{1'b1, AW'(2),  pack4(100, -100, -10, 0),   1'b0};
    vt[2] = '{1'b0, AW'(3),  pack4(10, -10, 0, 127),     1'b0};
    vt[3] = '{1'b1, AW'(3),  pack4(20, -20, 1, 1),       1'b0};
    vt[4] = '{1'b1, AW'(3),  pack4(20, -20, -1, 1),      1'b0};
    vt[5] = '{1'b0, AW'(26), 32'hFFFF_FFFF,              1'b1};
    vt[6] = '{1'b1, AW'(31), 32'h0101_0101,              1'b1};
    vt[7] = '{1'b0, AW'(25), pack4(-128, 127, -1, 64),   1'b0};
    for (int i = 0; i < 8; i++) begin
      write_row(int'(vt[i].addr), vt[i].data, vt[i].acc, vt[i].exp_err);
    end
    tick;
    chk("err_pulse_clears", 32'(err_oob), 32'd0);
    exp_rows[2]  = pack4(127, -128, -5, 0);
    exp_rows[3]  = pack4(50, -50, 0, 127);
    exp_rows[25] = pack4(-128, 127, -1, 64);

    // Full-rate drain with a dropped write to row 0 in the middle.
    run_drain(100, 1, -1);
    clear_expect(DP - 1);
    // Second consecutive drain: repeats data, or all zeros when clearing.
    run_drain(100, 0, -1);

    // Backpressure drain, with a write landing in the drain_start cycle.
    load_base_rows();
    run_drain(50, 2, -1);
    clear_expect(DP - 1);

    // Reset at beat 10, then drain again.
    load_base_rows();
    run_drain(100, 0, 10);
    clear_expect(10);
    run_drain(100, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
